// File: rtl/tow_playfield.sv
// Tug-of-war playfield: two synchronized key pulses pull a single lit position
// left or right; pushing past an edge latches that player as the winner.
module tow_playfield #(
  parameter int N           = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         KeyL,
  input  logic         KeyR,
  output logic         L,
  output logic         R,
  output logic         Le,
  output logic         Re,
  output logic [N-1:0] lights,
  output logic         GameOver
);

  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] POS_CENTER = PW'((N - 1) / 2);
  localparam logic [PW-1:0] POS_LEFT   = PW'(N - 1);
  localparam logic [PW-1:0] POS_RIGHT  = '0;

  // state | meaning
  // PLAY  | game running, pos drives one lit light
  // LWIN  | left player won, absorbing until Reset
  // RWIN  | right player won, absorbing until Reset
  typedef enum logic [1:0] {
    PLAY = 2'd0,
    LWIN = 2'd1,
    RWIN = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          pos_q, pos_d;
  logic [SYNC_STAGES-1:0] sync_l_q, sync_l_d;
  logic [SYNC_STAGES-1:0] sync_r_q, sync_r_d;
  logic [SYNC_STAGES-1:0] vld_q, vld_d;
  logic                   prev_l_q, prev_l_d;
  logic                   prev_r_q, prev_r_d;
  logic                   l_q, l_d;
  logic                   r_q, r_d;
  logic                   sync_l_out, sync_r_out, vld_out;

  assign sync_l_out = sync_l_q[SYNC_STAGES-1];
  assign sync_r_out = sync_r_q[SYNC_STAGES-1];
  assign vld_out    = vld_q[SYNC_STAGES-1];

  // vld marks when the synchronizer holds real key samples rather than reset
  // zeros; until then prev is held at 1 so a key held through reset cannot pulse.
  always_comb begin
    sync_l_d = {sync_l_q[SYNC_STAGES-2:0], KeyL};
    sync_r_d = {sync_r_q[SYNC_STAGES-2:0], KeyR};
    vld_d    = {vld_q[SYNC_STAGES-2:0], 1'b1};
    prev_l_d = vld_out ? sync_l_out : 1'b1;
    prev_r_d = vld_out ? sync_r_out : 1'b1;
    l_d      = vld_out & sync_l_out & ~prev_l_q;
    r_d      = vld_out & sync_r_out & ~prev_r_q;
  end

  always_comb begin
    Le       = (state_q == PLAY) && (pos_q == POS_LEFT);
    Re       = (state_q == PLAY) && (pos_q == POS_RIGHT);
    GameOver = (state_q != PLAY);
    lights   = (state_q == PLAY) ? (N'(1) << pos_q) : '0;
    L        = l_q;
    R        = r_q;
  end

  // A win takes precedence over movement, so pos never steps outside 0..N-1.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    case (state_q)
      PLAY: begin
        if (Le && l_q) begin
          state_d = LWIN;
        end else if (Re && r_q) begin
          state_d = RWIN;
        end else if (l_q && !r_q) begin
          pos_d = pos_q + PW'(1);
        end else if (!l_q && r_q) begin
          pos_d = pos_q - PW'(1);
        end
      end
      LWIN:    state_d = LWIN;
      RWIN:    state_d = RWIN;
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= PLAY;
      pos_q    <= POS_CENTER;
      sync_l_q <= '0;
      sync_r_q <= '0;
      vld_q    <= '0;
      prev_l_q <= 1'b1;
      prev_r_q <= 1'b1;
      l_q      <= 1'b0;
      r_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      sync_l_q <= sync_l_d;
      sync_r_q <= sync_r_d;
      vld_q    <= vld_d;
      prev_l_q <= prev_l_d;
      prev_r_q <= prev_r_d;
      l_q      <= l_d;
      r_q      <= r_d;
    end
  end

endmodule

// File: tb/tb_tow_playfield.sv
// Directed bench for tow_playfield (N=9, SYNC_STAGES=2): pulse timing,
// movement, edge wins, simultaneous presses and reset behaviour.
module tb_tow_playfield;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       KeyL;
  logic       KeyR;
  logic       L;
  logic       R;
  logic       Le;
  logic       Re;
  logic [8:0] lights;
  logic       GameOver;

  int n_tests = 0;
  int n_fail  = 0;

  tow_playfield #(.N(9), .SYNC_STAGES(2)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .KeyL    (KeyL),
    .KeyR    (KeyR),
    .L       (L),
    .R       (R),
    .Le      (Le),
    .Re      (Re),
    .lights  (lights),
    .GameOver(GameOver)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    KeyL  = 1'b0;
    KeyR  = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    repeat (4) tick();
  endtask

  task automatic press(input logic kl, input logic kr);
    KeyL = kl;
    KeyR = kr;
    repeat (3) tick();
    KeyL = 1'b0;
    KeyR = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    KeyL  = 1'b0;
    KeyR  = 1'b0;
    tick();
    n_tests++;
    if (lights !== 9'b000010000) begin n_fail++; $display("FAIL reset_lights got=%b exp=%b", lights, 9'b000010000); end
    n_tests++;
    if (Le !== 1'b0) begin n_fail++; $display("FAIL reset_le got=%b exp=0", Le); end
    n_tests++;
    if (Re !== 1'b0) begin n_fail++; $display("FAIL reset_re got=%b exp=0", Re); end
    n_tests++;
    if (GameOver !== 1'b0) begin n_fail++; $display("FAIL reset_gameover got=%b exp=0", GameOver); end
    n_tests++;
    if (L !== 1'b0 || R !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got L=%b R=%b exp 0 0", L, R); end
    tick();
    Reset = 1'b0;
    repeat (4) tick();
    n_tests++;
    if (lights !== 9'b000010000) begin n_fail++; $display("FAIL idle_lights got=%b exp=%b", lights, 9'b000010000); end
  endtask

  task automatic test_hold();
    int pulses;
    logic [8:0] exp_lights;
    pulses = 0;
    KeyL = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (L === 1'b1) pulses++;
      n_tests++;
      if (L !== (e == 3)) begin n_fail++; $display("FAIL hold_pulse edge=%0d got=%b exp=%b", e, L, (e == 3)); end
      exp_lights = (e <= 3) ? 9'b000010000 : 9'b000100000;
      n_tests++;
      if (lights !== exp_lights) begin n_fail++; $display("FAIL hold_lights edge=%0d got=%b exp=%b", e, lights, exp_lights); end
    end
    KeyL = 1'b0;
    repeat (6) tick();
    n_tests++;
    if (pulses != 1) begin n_fail++; $display("FAIL hold_pulse_count got=%0d exp=1", pulses); end
    n_tests++;
    if (lights !== 9'b000100000) begin n_fail++; $display("FAIL hold_final_lights got=%b exp=%b", lights, 9'b000100000); end
  endtask

  task automatic test_walk_left();
    logic found;
    do_reset();
    repeat (4) press(1'b1, 1'b0);
    n_tests++;
    if (lights !== 9'b100000000) begin n_fail++; $display("FAIL walk_lights got=%b exp=%b", lights, 9'b100000000); end
    n_tests++;
    if (Le !== 1'b1 || Re !== 1'b0) begin n_fail++; $display("FAIL walk_edges got Le=%b Re=%b exp 1 0", Le, Re); end
    KeyL  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (L === 1'b1) found = 1'b1;
    end
    n_tests++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL walk_win_pulse got=%b exp=1", found); end
    n_tests++;
    if (Le !== 1'b1 || GameOver !== 1'b0) begin n_fail++; $display("FAIL walk_pulse_cycle got Le=%b GO=%b exp 1 0", Le, GameOver); end
    tick();
    n_tests++;
    if (GameOver !== 1'b1 || lights !== 9'b0) begin n_fail++; $display("FAIL walk_win got GO=%b lights=%b exp 1 0", GameOver, lights); end
    n_tests++;
    if (Le !== 1'b0 || Re !== 1'b0) begin n_fail++; $display("FAIL walk_win_edges got Le=%b Re=%b exp 0 0", Le, Re); end
    KeyL = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_both_center();
    do_reset();
    KeyL = 1'b1;
    KeyR = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (L !== 1'b1 || R !== 1'b1) begin n_fail++; $display("FAIL both_pulses got L=%b R=%b exp 1 1", L, R); end
    tick();
    n_tests++;
    if (lights !== 9'b000010000) begin n_fail++; $display("FAIL both_lights got=%b exp=%b", lights, 9'b000010000); end
    n_tests++;
    if (L !== 1'b0 || R !== 1'b0) begin n_fail++; $display("FAIL both_single got L=%b R=%b exp 0 0", L, R); end
    KeyL = 1'b0;
    KeyR = 1'b0;
    repeat (4) tick();
    n_tests++;
    if (lights !== 9'b000010000 || GameOver !== 1'b0) begin n_fail++; $display("FAIL both_settled got lights=%b GO=%b exp %b 0", lights, GameOver, 9'b000010000); end
  endtask

  task automatic test_edge_both();
    logic [1:0] st;
    do_reset();
    repeat (4) press(1'b1, 1'b0);
    n_tests++;
    if (Le !== 1'b1) begin n_fail++; $display("FAIL edge_le got=%b exp=1", Le); end
    press(1'b1, 1'b1);
    st = dut.state_q;
    n_tests++;
    if (st !== 2'd1) begin n_fail++; $display("FAIL edge_both_state got=%0d exp=1", st); end
    n_tests++;
    if (GameOver !== 1'b1 || lights !== 9'b0) begin n_fail++; $display("FAIL edge_both_win got GO=%b lights=%b exp 1 0", GameOver, lights); end
  endtask

  task automatic test_right_win();
    logic [1:0] st;
    logic found;
    do_reset();
    repeat (4) press(1'b0, 1'b1);
    n_tests++;
    if (lights !== 9'b000000001) begin n_fail++; $display("FAIL right_lights got=%b exp=%b", lights, 9'b000000001); end
    n_tests++;
    if (Re !== 1'b1 || Le !== 1'b0) begin n_fail++; $display("FAIL right_edges got Le=%b Re=%b exp 0 1", Le, Re); end
    press(1'b0, 1'b1);
    st = dut.state_q;
    n_tests++;
    if (st !== 2'd2) begin n_fail++; $display("FAIL right_state got=%0d exp=2", st); end
    n_tests++;
    if (GameOver !== 1'b1 || lights !== 9'b0 || Re !== 1'b0) begin n_fail++; $display("FAIL right_win got GO=%b lights=%b Re=%b exp 1 0 0", GameOver, lights, Re); end
    KeyL  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (L === 1'b1) found = 1'b1;
    end
    n_tests++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL right_win_pulse got=%b exp=1", found); end
    KeyL = 1'b0;
    repeat (4) tick();
    press(1'b0, 1'b1);
    n_tests++;
    if (GameOver !== 1'b1 || lights !== 9'b0) begin n_fail++; $display("FAIL right_absorb got GO=%b lights=%b exp 1 0", GameOver, lights); end
  endtask

  task automatic test_reset_in_win();
    int pulses;
    KeyR = 1'b1;
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    n_tests++;
    if (lights !== 9'b000010000 || GameOver !== 1'b0) begin n_fail++; $display("FAIL rst_win got lights=%b GO=%b exp %b 0", lights, GameOver, 9'b000010000); end
    Reset  = 1'b0;
    pulses = 0;
    repeat (8) begin
      tick();
      if (R === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin n_fail++; $display("FAIL rst_held_pulses got=%0d exp=0", pulses); end
    n_tests++;
    if (lights !== 9'b000010000) begin n_fail++; $display("FAIL rst_held_lights got=%b exp=%b", lights, 9'b000010000); end
    KeyR = 1'b0;
    repeat (4) tick();
    KeyR   = 1'b1;
    pulses = 0;
    repeat (6) begin
      tick();
      if (R === 1'b1) pulses++;
    end
    KeyR = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (pulses != 1) begin n_fail++; $display("FAIL rst_repress_pulses got=%0d exp=1", pulses); end
    n_tests++;
    if (lights !== 9'b000001000) begin n_fail++; $display("FAIL rst_repress_lights got=%b exp=%b", lights, 9'b000001000); end
  endtask

  initial begin
    Reset = 1'b1;
    KeyL  = 1'b0;
    KeyR  = 1'b0;
    @(negedge Clock);
    test_reset();
    test_hold();
    test_walk_left();
    test_both_center();
    test_edge_both();
    test_right_win();
    test_reset_in_win();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tow_playfield.md
TOW_PLAYFIELD -- requirements
Module: tow_playfield

Interface
REQ-001 Parameter N, default 9, number of playfield lights; SHALL be odd, 3..15.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth per key; SHALL be 2..4.
REQ-003 Clock  input  1  system clock; all state SHALL update on its rising edge only.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 KeyL  input  1  raw left-player button, active-high, asynchronous to Clock.
REQ-006 KeyR  input  1  raw right-player button, active-high, asynchronous to Clock.
REQ-007 L  output  1  registered single-cycle left-press pulse.
REQ-008 R  output  1  registered single-cycle right-press pulse.
REQ-009 Le  output  1  left edge light lit; next left press wins.
REQ-010 Re  output  1  right edge light lit; next right press wins.
REQ-011 lights  output  N  one-hot playfield; lights[N-1] is the leftmost light, lights[0] the rightmost.
REQ-012 GameOver  output  1  high while a winner is latched.

Function
REQ-013 Each key SHALL pass through a SYNC_STAGES-flop synchronizer before any other use.
REQ-014 A previous-value flop SHALL hold the last synchronized value of each key.
REQ-015 L SHALL be 1 for exactly one cycle when the synchronized KeyL is 1 and its previous value is 0; R SHALL follow the same rule with KeyR.
REQ-016 Pulse latency SHALL be fixed: L rises on clock edge SYNC_STAGES+1, counting the first edge that samples KeyL=1 as edge 1 (edge 3 at default).
REQ-017 A held key SHALL produce no further pulses; one release and a new press SHALL produce exactly one new pulse.
REQ-018 A position register pos (0..N-1, width ceil(log2 N)) SHALL drive lights: lights[pos]=1 and all other bits 0 in PLAY.
REQ-019 Le SHALL equal (pos==N-1) and Re SHALL equal (pos==0), decoded combinationally from the pos register, so both are valid in the same cycle as L/R.
REQ-020 The FSM SHALL have states PLAY, LWIN and RWIN.
REQ-021 In PLAY, Le=1 and L=1 SHALL go to LWIN on the next edge, regardless of R.
REQ-022 In PLAY, Re=1 and R=1 SHALL go to RWIN on the next edge, regardless of L.
REQ-023 In PLAY with no win, L=1 and R=0 SHALL set pos to pos+1; L=0 and R=1 SHALL set pos to pos-1; L=1 and R=1 SHALL leave pos unchanged.
REQ-024 pos SHALL never leave the range 0..N-1 (no wrap-around); a move past an edge is by definition a win.
REQ-025 lights SHALL update on the edge that ends the pulse cycle, one cycle after L or R is observed.
REQ-026 LWIN and RWIN SHALL be absorbing until Reset.
REQ-027 In LWIN and RWIN, pos SHALL be frozen; lights SHALL be all 0, Le and Re SHALL be 0, and GameOver SHALL be 1.
REQ-028 In LWIN and RWIN, L and R pulse generation SHALL continue.
REQ-029 GameOver SHALL be 0 in PLAY.
REQ-030 Le and Re SHALL never both be 1.

Reset
REQ-031 Reset, sampled high on an edge, SHALL set: state PLAY; pos=(N-1)/2; synchronizer flops to 0; previous-value flops to 1; L=0, R=0.
REQ-032 Reset SHALL take priority over every other event, including a simultaneous win or press.
REQ-033 A key held through reset SHALL produce no pulse until it is released and pressed again.
REQ-034 Reset asserted mid-game or in LWIN/RWIN SHALL return to the center light on the next edge.
REQ-035 Post-reset outputs (N=9) SHALL be: lights=9'b000010000, Le=0, Re=0, GameOver=0, L=0, R=0.

Verification
REQ-036 The bench SHALL cover reset, then KeyL held high for 10 cycles: exactly one L pulse, on edge 3; lights become 9'b000100000 one cycle after the pulse; no further movement.
REQ-037 The bench SHALL cover four separate KeyL presses from center: lights reach 9'b100000000 and Le=1; a fifth press gives L=1 with Le=1, GameOver=1 on the next edge, lights=0.
REQ-038 The bench SHALL cover KeyL and KeyR pressed in the same cycle at center: L=1 and R=1 together; pos stays 4; lights unchanged.
REQ-039 The bench SHALL cover pos=8 (Le=1) with simultaneous L and R: state LWIN.
REQ-040 The bench SHALL cover pos=0 with R only: state RWIN; subsequent presses leave GameOver=1 and lights=0.
REQ-041 The bench SHALL cover Reset asserted in RWIN with KeyR held: next edge gives lights=9'b000010000 and GameOver=0; no R pulse until KeyR is released and re-pressed.
